// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one done-handshake main-memory port between
// two requesters, with a BUSY watchdog that turns a hung transfer into an error.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              read_write0,
  input  logic              read_write1,
  input  logic [ADDR_W-1:0] address0,
  input  logic [ADDR_W-1:0] address1,
  input  logic [LINE_W-1:0] write_data0,
  input  logic [LINE_W-1:0] write_data1,
  output logic [LINE_W-1:0] read_data0,
  output logic [LINE_W-1:0] read_data1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              mem_req,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_write_data,
  input  logic [LINE_W-1:0] mem_read_data,
  input  logic              mem_done
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

  logic [1:0]             req, rw;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][LINE_W-1:0] wdata;

  assign req   = {req1, req0};
  assign rw    = {read_write1, read_write0};
  assign addr  = {address1, address0};
  assign wdata = {write_data1, write_data0};

  state_t                 state_q, state_d;
  logic                   gnt_q, gnt_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       wd_q, wd_d;
  logic                   mreq_q, mreq_d;
  logic                   mrw_q, mrw_d;
  logic [ADDR_W-1:0]      maddr_q, maddr_d;
  logic [LINE_W-1:0]      mwdata_q, mwdata_d;
  logic [1:0][LINE_W-1:0] rdata_q, rdata_d;
  logic [1:0]             done_q, done_d;
  logic [1:0]             err_q, err_d;
  logic                   pick;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wd_d     = wd_q;
    mreq_d   = mreq_q;
    mrw_d    = mrw_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    done_d   = '0;
    err_d    = '0;
    pick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the requester that did not win last time goes first.
          pick     = (&req) ? ~last_q : req[1];
          gnt_d    = pick;
          last_d   = pick;
          mrw_d    = rw[pick];
          maddr_d  = addr[pick];
          mwdata_d = wdata[pick];
          mreq_d   = 1'b1;
          wd_d     = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mem_done) begin
          mreq_d = 1'b0;
          if (!mrw_q) rdata_d[gnt_q] = mem_read_data;
          done_d[gnt_q] = 1'b1;
          state_d = RESP;
        end else if (WD_EN && wd_q == WD_LAST) begin
          mreq_d = 1'b0;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
          state_d = RESP;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      wd_q     <= '0;
      mreq_q   <= 1'b0;
      mrw_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      mreq_q   <= mreq_d;
      mrw_q    <= mrw_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign read_data0     = rdata_q[0];
  assign read_data1     = rdata_q[1];
  assign done0          = done_q[0];
  assign done1          = done_q[1];
  assign err0           = err_q[0];
  assign err1           = err_q[1];
  assign mem_req        = mreq_q;
  assign mem_read_write = mrw_q;
  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration table, directed corner sequences and
// a randomized run scored against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int LW = 128;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, read_write0, read_write1, mem_done;
  logic [AW-1:0] address0, address1;
  logic [LW-1:0] write_data0, write_data1, mem_read_data;

  logic [LW-1:0] read_data0, read_data1, mem_write_data;
  logic          done0, done1, err0, err1, mem_req, mem_read_write;
  logic [AW-1:0] mem_address;

  logic [LW-1:0] nt_read_data0, nt_read_data1, nt_mem_write_data;
  logic          nt_done0, nt_done1, nt_err0, nt_err1, nt_mem_req, nt_mem_read_write;
  logic [AW-1:0] nt_mem_address;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .read_write0(read_write0), .read_write1(read_write1),
    .address0(address0), .address1(address1),
    .write_data0(write_data0), .write_data1(write_data1),
    .read_data0(read_data0), .read_data1(read_data1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .mem_req(mem_req), .mem_read_write(mem_read_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_done(mem_done));

  // Watchdog disabled: a stalled transfer must stay in BUSY.
  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(0), .CNT_W(5)) dut_nt (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .read_write0(read_write0), .read_write1(read_write1),
    .address0(address0), .address1(address1),
    .write_data0(write_data0), .write_data1(write_data1),
    .read_data0(nt_read_data0), .read_data1(nt_read_data1),
    .done0(nt_done0), .done1(nt_done1), .err0(nt_err0), .err1(nt_err1),
    .mem_req(nt_mem_req), .mem_read_write(nt_mem_read_write),
    .mem_address(nt_mem_address), .mem_write_data(nt_mem_write_data),
    .mem_read_data(mem_read_data), .mem_done(mem_done));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; read_write0 = 1'b0; read_write1 = 1'b0;
    address0 = '0; address1 = '0; write_data0 = '0; write_data1 = '0;
    mem_read_data = '0; mem_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic          r0, r1, md;
    logic          e_mreq, e_d0, e_d1;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tbl[14];

  // Random-run model state.
  logic          pend[2];
  logic          rw_m[2];
  logic [AW-1:0] ad_m[2];
  logic [LW-1:0] wd_m[2];
  logic [LW-1:0] exp_rd[2];
  logic [LW-1:0] mrd_e;
  logic [1:0]    req_e;
  logic          md_e, busy_prev, done_prev, e_mreq;
  logic [1:0]    e_done, e_err;
  int            last_g, g, busy_len, mdly, cnt;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h011};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h011};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h011};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h022};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h022};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h022};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h011};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h011};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h011};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h022};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h022};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h022};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h022};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h022};

    // Reset state
    do_reset();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_rw", mem_read_write, 1'b0);
    chka("rst_mem_addr", mem_address, '0);
    chkw("rst_mem_wdata", mem_write_data, '0);
    chkw("rst_rdata0", read_data0, '0);
    chkw("rst_rdata1", read_data1, '0);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_done1", done1, 1'b0);
    chk1("rst_err0", err0, 1'b0);
    chk1("rst_err1", err1, 1'b0);

    // Round-robin table: both requesters contending, order 0,1,0,1
    address0 = 10'h011; address1 = 10'h022; mem_read_data = 128'hC0DE;
    for (int i = 0; i < 14; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; mem_done = tbl[i].md;
      step();
      chk1($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_mreq);
      chk1($sformatf("tbl%0d_done0", i), done0, tbl[i].e_d0);
      chk1($sformatf("tbl%0d_done1", i), done1, tbl[i].e_d1);
      chka($sformatf("tbl%0d_addr", i), mem_address, tbl[i].e_addr);
    end

    // Single read, memory answers 3 cycles after mem_req
    do_reset();
    req0 = 1'b1; read_write0 = 1'b0; address0 = 10'h008;
    step();
    chk1("rd_mem_req_rise", mem_req, 1'b1);
    chka("rd_mem_addr", mem_address, 10'h008);
    chk1("rd_mem_rw", mem_read_write, 1'b0);
    step();
    step();
    chk1("rd_mem_req_held", mem_req, 1'b1);
    mem_done = 1'b1; mem_read_data = {16{8'hA5}};
    step();
    chk1("rd_done0", done0, 1'b1);
    chk1("rd_err0", err0, 1'b0);
    chk1("rd_done1", done1, 1'b0);
    chkw("rd_rdata0", read_data0, {16{8'hA5}});
    chk1("rd_mem_req_fall", mem_req, 1'b0);
    req0 = 1'b0; mem_done = 1'b0;
    step();
    chk1("rd_done0_pulse", done0, 1'b0);

    // Write from requester 1; read_data1 must not take the memory line
    req1 = 1'b1; read_write1 = 1'b1; address1 = 10'h3FC; write_data1 = {8{16'h1234}};
    step();
    chk1("wr_mem_rw", mem_read_write, 1'b1);
    chka("wr_mem_addr", mem_address, 10'h3FC);
    chkw("wr_mem_wdata", mem_write_data, {8{16'h1234}});
    step();
    mem_done = 1'b1; mem_read_data = '1;
    step();
    chk1("wr_done1", done1, 1'b1);
    chk1("wr_err1", err1, 1'b0);
    chkw("wr_rdata1", read_data1, '0);
    chkw("wr_rdata0_kept", read_data0, {16{8'hA5}});
    req1 = 1'b0; mem_done = 1'b0;
    step();
    chk1("wr_done1_pulse", done1, 1'b0);

    // Watchdog: memory never answers
    do_reset();
    req0 = 1'b1; address0 = 10'h055;
    step();
    cnt = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      cnt++;
      step();
    end
    chki("to_busy_cycles", cnt, TO);
    chk1("to_done0", done0, 1'b1);
    chk1("to_err0", err0, 1'b1);
    chk1("to_done1", done1, 1'b0);
    chk1("to_nt_mem_req", nt_mem_req, 1'b1);
    req0 = 1'b0;
    step();
    chk1("to_done0_pulse", done0, 1'b0);
    chk1("to_err0_pulse", err0, 1'b0);
    repeat (10) step();
    chk1("to_nt_still_busy", nt_mem_req, 1'b1);
    chk1("to_nt_no_done", nt_done0, 1'b0);

    // Reset in the middle of a transfer
    do_reset();
    req1 = 1'b1; read_write1 = 1'b0; address1 = 10'h0AB;
    step();
    chk1("mr_mem_req", mem_req, 1'b1);
    step();
    step();
    reset = 1'b1;
    #1;
    chk1("mr_async_mem_req", mem_req, 1'b0);
    chka("mr_async_addr", mem_address, '0);
    @(posedge clock);
    #1;
    chk1("mr_no_done1", done1, 1'b0);
    reset = 1'b0;
    step();
    chk1("mr_regrant_req", mem_req, 1'b1);
    chka("mr_regrant_addr", mem_address, 10'h0AB);
    chk1("mr_regrant_no_done", done1, 1'b0);

    // Randomized run against the transaction model
    do_reset();
    pend = '{1'b0, 1'b0};
    exp_rd = '{'0, '0};
    rw_m = '{1'b0, 1'b0};
    ad_m = '{'0, '0};
    wd_m = '{'0, '0};
    last_g = 1; g = 0; busy_len = 0; mdly = 0;
    busy_prev = 1'b0; done_prev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(2) == 0) begin
          pend[r] = 1'b1;
          rw_m[r] = 1'($urandom_range(1));
          ad_m[r] = AW'($urandom);
          wd_m[r] = {4{$urandom}};
        end
      end
      req0 = pend[0]; read_write0 = rw_m[0]; address0 = ad_m[0]; write_data0 = wd_m[0];
      req1 = pend[1]; read_write1 = rw_m[1]; address1 = ad_m[1]; write_data1 = wd_m[1];
      if (busy_prev) mem_done = (busy_len == mdly);
      else           mem_done = ($urandom_range(3) == 0);
      mem_read_data = {4{$urandom}};
      req_e = {req1, req0}; md_e = mem_done; mrd_e = mem_read_data;

      step();

      e_done = 2'b00; e_err = 2'b00; e_mreq = 1'b0;
      if (busy_prev) begin
        if (md_e) begin
          e_done[g] = 1'b1;
          if (!rw_m[g]) exp_rd[g] = mrd_e;
          pend[g] = 1'b0;
        end else if (busy_len == TO) begin
          e_done[g] = 1'b1;
          e_err[g]  = 1'b1;
          pend[g] = 1'b0;
        end else begin
          e_mreq = 1'b1;
          busy_len++;
        end
      end else if (!done_prev && req_e != 2'b00) begin
        if (req_e == 2'b11) g = 1 - last_g;
        else                g = req_e[1] ? 1 : 0;
        last_g = g;
        e_mreq = 1'b1;
        busy_len = 1;
        case ($urandom_range(9))
          6:       mdly = 15;
          7:       mdly = 16;
          8, 9:    mdly = 99;
          default: mdly = 1 + int'($urandom_range(3));
        endcase
      end

      chk1("rnd_mem_req", mem_req, e_mreq);
      chk1("rnd_done0", done0, e_done[0]);
      chk1("rnd_done1", done1, e_done[1]);
      chk1("rnd_err0", err0, e_err[0]);
      chk1("rnd_err1", err1, e_err[1]);
      chkw("rnd_rdata0", read_data0, exp_rd[0]);
      chkw("rnd_rdata1", read_data1, exp_rd[1]);
      if (e_mreq) begin
        chka("rnd_mem_addr", mem_address, ad_m[g]);
        chk1("rnd_mem_rw", mem_read_write, rw_m[g]);
        chkw("rnd_mem_wdata", mem_write_data, wd_m[g]);
      end
      busy_prev = e_mreq;
      done_prev = |e_done;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
